cs_com_tx: RTL and testbench

- Far-end transmitter for the two-wire com0/com1 link between device groups.
- Answers the configuration handshake started by the receiving group.
- After configuration, sends one framed 4-bit data id per request: a ready strobe on com0[1], then the id twice (data + check) as 2-bit nibbles on com1, each nibble pair qualified by a strobe on com0[0].
- Sits in the ADC-side group, fed by the ADC data-id counter.

---
 rtl/cs_com_pkg.sv | 49 ++++
 rtl/com_sync.sv | 33 +++
 rtl/cs_com_tx.sv | 183 ++++++++++++++++++
 tb/tb_cs_com_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_com_pkg.sv
// ============================================================================
//  cs_com_pkg : shared state encodings and link codes for the com0/com1 link.
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package cs_com_pkg;

    // MAIN group
    localparam logic [7:0] ST_IDLE      = 8'h00;
    // CONF group
    localparam logic [7:0] ST_CONF_WTBG = 8'h10;
    localparam logic [7:0] ST_CONF_ACK  = 8'h11;
    localparam logic [7:0] ST_CONF_REL  = 8'h12;
    // WORK group
    localparam logic [7:0] ST_WORK_IDLE = 8'h20;
    localparam logic [7:0] ST_WORK_DONE = 8'h21;
    // SEND group
    localparam logic [7:0] ST_SEND_RDY  = 8'h30;
    localparam logic [7:0] ST_SEND_GAP  = 8'h31;
    localparam logic [7:0] ST_NIB_HI    = 8'h32;
    localparam logic [7:0] ST_STB_HI    = 8'h33;
    localparam logic [7:0] ST_NIB_LO    = 8'h34;
    localparam logic [7:0] ST_STB_LO    = 8'h35;

    typedef enum logic [7:0] {
        IDLE      = ST_IDLE,
        CONF_WTBG = ST_CONF_WTBG,
        CONF_ACK  = ST_CONF_ACK,
        CONF_REL  = ST_CONF_REL,
        WORK_IDLE = ST_WORK_IDLE,
        DONE      = ST_WORK_DONE,
        SEND_RDY  = ST_SEND_RDY,
        SEND_GAP  = ST_SEND_GAP,
        NIB_HI    = ST_NIB_HI,
        STB_HI    = ST_STB_HI,
        NIB_LO    = ST_NIB_LO,
        STB_LO    = ST_STB_LO
    } state_e;

    localparam logic [1:0] COM_ACK = 2'h3;
    localparam logic [1:0] COM_REL = 2'h0;

    localparam int HOLD_DEF = 4;
    localparam int TURN_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/com_sync.sv
// ============================================================================
//  com_sync : two-flop synchronizer with synchronous clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module com_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/cs_com_tx.sv
// ============================================================================
//  cs_com_tx : far-end transmitter; answers the configuration handshake, then
//              sends framed 4-bit data ids over com0/com1.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module cs_com_tx
    import cs_com_pkg::*;
#(
    parameter int HOLD  = HOLD_DEF,
    parameter int TURN  = TURN_DEF,
    parameter int CNT_W = 3
) (
    input  logic       sys_clk,
    input  logic       rst,
    inout  wire  [1:0] com0,
    output logic [1:0] com1,
    input  logic       conf_req,
    input  logic       send,
    input  logic [3:0] dat_id,
    output logic       busy,
    output logic       fd_conf,
    output logic       fd_send
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       id_q;
    logic             pass_q;
    logic [1:0]       com0_q;
    logic             com0_oe_q;
    logic [1:0]       com1_q;
    logic             busy_q;
    logic             fd_conf_q;
    logic             fd_send_q;

    logic [1:0]       w_com0_s;
    logic             w_hold_done;
    logic             w_turn_done;

    com_sync #(
        .WIDTH (2)
    ) u_sync (
        .clk (sys_clk),
        .rst (rst),
        .d_i (com0),
        .q_o (w_com0_s)
    );

    assign w_hold_done = (cnt_q == CNT_W'(HOLD - 1));
    assign w_turn_done = (cnt_q == CNT_W'(TURN - 1));

    // cnt_q defaults to zero so every state change reloads it; timed states
    // override the default with an increment until their phase completes.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_q      <= 4'h0;
            pass_q    <= 1'b0;
            com0_q    <= 2'b00;
            com0_oe_q <= 1'b0;
            com1_q    <= COM_REL;
            busy_q    <= 1'b0;
            fd_conf_q <= 1'b0;
            fd_send_q <= 1'b0;
        end else begin
            cnt_q     <= '0;
            fd_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conf_req) begin
                        state_q <= CONF_WTBG;
                        com1_q  <= COM_REL;
                    end
                end
                CONF_WTBG: begin
                    if (w_com0_s[1]) begin
                        state_q <= CONF_ACK;
                        com1_q  <= COM_ACK;
                    end
                end
                CONF_ACK: begin
                    if (w_com0_s[0]) begin
                        state_q <= CONF_REL;
                        com1_q  <= COM_REL;
                    end
                end
                CONF_REL: begin
                    if (w_turn_done) begin
                        state_q   <= WORK_IDLE;
                        fd_conf_q <= 1'b1;
                        com0_oe_q <= 1'b1;
                        com0_q    <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WORK_IDLE: begin
                    if (send && !busy_q) begin
                        state_q <= SEND_RDY;
                        id_q    <= dat_id;
                        busy_q  <= 1'b1;
                        com0_q  <= 2'b10;
                    end
                end
                SEND_RDY: begin
                    if (w_hold_done) begin
                        state_q <= SEND_GAP;
                        com0_q  <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SEND_GAP: begin
                    pass_q <= 1'b0;
                    if (w_hold_done) begin
                        state_q <= NIB_HI;
                        com1_q  <= id_q[3:2];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                NIB_HI: begin
                    if (w_hold_done) begin
                        state_q <= STB_HI;
                        com0_q  <= 2'b01;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STB_HI: begin
                    if (w_hold_done) begin
                        state_q <= NIB_LO;
                        com1_q  <= id_q[1:0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                NIB_LO: begin
                    if (w_hold_done) begin
                        state_q <= STB_LO;
                        com0_q  <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STB_LO: begin
                    if (w_hold_done) begin
                        if (!pass_q) begin
                            state_q <= NIB_HI;
                            pass_q  <= 1'b1;
                            com1_q  <= id_q[3:2];
                        end else begin
                            state_q   <= DONE;
                            fd_send_q <= 1'b1;
                            busy_q    <= 1'b0;
                            com1_q    <= COM_REL;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= WORK_IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign com0    = com0_oe_q ? com0_q : 2'bzz;
    assign com1    = com1_q;
    assign busy    = busy_q;
    assign fd_conf = fd_conf_q;
    assign fd_send = fd_send_q;

endmodule

`default_nettype wire

// File: tb/tb_cs_com_tx.sv
// ============================================================================
//  tb_cs_com_tx : bench for cs_com_tx with a receiver model on the link.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_cs_com_tx;

    localparam int H = 4;
    localparam int T = 4;
    localparam int FRAME = 10 * H + 1;

    logic       sys_clk;
    logic       rst;
    logic       conf_req;
    logic       send;
    logic [3:0] dat_id;
    logic [1:0] com1;
    logic       busy;
    logic       fd_conf;
    logic       fd_send;
    wire  [1:0] com0_w;
    logic       tb_oe;
    logic [1:0] tb_val;

    // An undriven com0 reads back as 2'b11.
    assign com0_w = tb_oe ? tb_val : 2'bzz;
    pullup pu0 (com0_w[0]);
    pullup pu1 (com0_w[1]);

    cs_com_tx #(
        .HOLD  (H),
        .TURN  (T),
        .CNT_W (3)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .com0     (com0_w),
        .com1     (com1),
        .conf_req (conf_req),
        .send     (send),
        .dat_id   (dat_id),
        .busy     (busy),
        .fd_conf  (fd_conf),
        .fd_send  (fd_send)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Link model: which phase the far end should be in and where in a frame.
    localparam int M_IDLE = 0, M_WTBG = 1, M_ACK = 2, M_REL = 3, M_WORK = 4;
    int         m_mode = M_IDLE;
    int         m_t    = 0;
    int         m_cnt  = 0;
    logic [3:0] m_id   = 4'h0;
    logic [1:0] m_com1 = 2'b00;
    logic [1:0] m_s1   = 2'b00;
    logic [1:0] m_s2   = 2'b00;

    always @(posedge sys_clk) begin
        m_s1 <= com0_w;
        m_s2 <= m_s1;
        if (rst) begin
            m_mode <= M_IDLE; m_t <= 0; m_cnt <= 0; m_id <= 4'h0;
            m_com1 <= 2'b00; m_s1 <= 2'b00; m_s2 <= 2'b00;
        end else begin
            case (m_mode)
                M_IDLE: if (conf_req) begin m_mode <= M_WTBG; m_com1 <= 2'b00; end
                M_WTBG: if (m_s2[1]) begin m_mode <= M_ACK; m_com1 <= 2'b11; end
                M_ACK:  if (m_s2[0]) begin m_mode <= M_REL; m_com1 <= 2'b00; m_cnt <= 0; end
                M_REL:  if (m_cnt == T - 1) begin m_mode <= M_WORK; m_t <= 0; end
                        else m_cnt <= m_cnt + 1;
                default: begin
                    if (m_t == 0) begin
                        if (send) begin m_t <= 1; m_id <= dat_id; end
                    end else if (m_t < FRAME) m_t <= m_t + 1;
                    else m_t <= 0;
                end
            endcase
        end
    end

    logic [1:0] e0, e1;
    logic       eb, ec, ef;
    int         ph;

    always @(negedge sys_clk) begin
        if (chk_en) begin
            e0 = 2'b11; e1 = m_com1; eb = 1'b0; ec = 1'b0; ef = 1'b0;
            if (m_mode == M_WORK) begin
                ec = 1'b1; e0 = 2'b00; e1 = 2'b00;
                if (m_t >= 1 && m_t <= H) begin
                    e0 = 2'b10; eb = 1'b1;
                end else if (m_t > H && m_t <= 2 * H) begin
                    eb = 1'b1;
                end else if (m_t > 2 * H && m_t <= 10 * H) begin
                    ph = ((m_t - 2 * H - 1) / H) % 4;
                    e1 = (ph < 2) ? m_id[3:2] : m_id[1:0];
                    e0 = {1'b0, (ph == 1 || ph == 2)};
                    eb = 1'b1;
                end else if (m_t == FRAME) begin
                    ef = 1'b1;
                end
            end
            chk("com1", com1, e1);
            chk("busy", busy, eb);
            chk("fd_conf", fd_conf, ec);
            chk("fd_send", fd_send, ef);
            if (!tb_oe) chk("com0", com0_w, e0);
        end
    end

    // Receiver decoder: high nibble on strobe rise, low nibble on strobe fall.
    logic       rx_prev = 1'b0;
    logic       rx_n    = 1'b0;
    logic [1:0] rx_hi   = 2'b00;
    logic [3:0] rx_d    = 4'h0;
    logic [7:0] rx_q[$];

    always @(negedge sys_clk) begin
        if (rst) begin
            rx_prev <= 1'b0;
            rx_n    <= 1'b0;
        end else if (fd_conf === 1'b1) begin
            if (!rx_prev && com0_w[0]) rx_hi <= com1;
            if (rx_prev && !com0_w[0]) begin
                if (rx_n) begin
                    rx_q.push_back({rx_d, rx_hi, com1});
                    rx_n <= 1'b0;
                end else begin
                    rx_d <= {rx_hi, com1};
                    rx_n <= 1'b1;
                end
            end
            rx_prev <= com0_w[0];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp);
        logic [31:0] got;
        got = (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'hFFFF_FFFF;
        chk(nm, got, {24'h0, exp});
    endtask

    task automatic wait_com1(input logic [1:0] v, output int lat);
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            if (com1 === v) begin lat = k; break; end
        end
    endtask

    task automatic configure(input bit with_send);
        int lat;
        int hit;
        tb_oe = 1'b1; tb_val = 2'b00;
        cyc(4);
        conf_req = 1'b1;
        if (with_send) begin send = 1'b1; dat_id = 4'h9; end
        cyc(1);
        send = 1'b0;
        cyc(1);
        conf_req = 1'b0;
        cyc(2);
        chk("conf_wait_com1", com1, 2'b00);
        tb_val = 2'b10;
        wait_com1(2'b11, lat);
        chk("ack_within_3", (lat <= 3), 1);
        tb_val = 2'b01;
        wait_com1(2'b00, lat);
        chk("rel_within_3", (lat <= 3), 1);
        tb_oe = 1'b0;
        hit = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (fd_conf === 1'b1) begin hit = k; break; end
            chk("conf_com0_z", com0_w, 2'b11);
        end
        chk("fd_conf_set", fd_conf, 1'b1);
        chk("work_com0_00", com0_w, 2'b00);
    endtask

    task automatic run_frame(input logic [3:0] id, input bit inject, output int lat, output int rdy);
        send = 1'b1; dat_id = id;
        lat = 0; rdy = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc(1);
            if (k == 1) send = 1'b0;
            if (inject && k == 20) begin send = 1'b1; dat_id = 4'h5; end
            if (inject && k == 21) send = 1'b0;
            if (com0_w[1] === 1'b1) rdy++;
            if (fd_send === 1'b1) begin lat = k; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int rdy;
        rst = 1'b1; conf_req = 1'b0; send = 1'b0; dat_id = 4'h0;
        tb_oe = 1'b0; tb_val = 2'b00;
        cyc(3);
        chk_en = 1'b1;
        chk("rst_com0_z", com0_w, 2'b11);
        chk("rst_com1", com1, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fd_conf", fd_conf, 1'b0);
        rst = 1'b0;

        // send before configuration is dropped
        send = 1'b1; dat_id = 4'h7;
        cyc(1);
        send = 1'b0;
        cyc(6);
        chk("idle_busy", busy, 1'b0);
        chk("idle_com0_z", com0_w, 2'b11);

        configure(1'b1);
        chk("conf_send_dropped", rx_q.size(), 0);
        cyc(2);

        run_frame(4'hB, 1'b1, lat, rdy);
        chk("lat_B", lat, 41);
        chk("rdy_B", rdy, 4);
        cyc(1);
        chk_rx("rx_B", 8'hBB);
        chk("busy_reject_no_extra", rx_q.size(), 0);

        run_frame(4'h5, 1'b0, lat, rdy);
        chk("lat_5", lat, 41);
        // send during DONE must be ignored
        send = 1'b1; dat_id = 4'hA;
        cyc(1);
        send = 1'b0;
        cyc(50);
        chk("done_send_ignored_busy", busy, 1'b0);
        chk_rx("rx_5", 8'h55);
        chk("done_send_no_frame", rx_q.size(), 0);

        // reset in the middle of STB_HI
        send = 1'b1; dat_id = 4'h6;
        cyc(1);
        send = 1'b0;
        cyc(13);
        chk("abort_in_stb_hi", com0_w, 2'b01);
        rst = 1'b1;
        cyc(1);
        chk("abort_com0_z", com0_w, 2'b11);
        chk("abort_com1", com1, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_fd_conf", fd_conf, 1'b0);
        rst = 1'b0;
        cyc(2);
        chk("abort_no_frame", rx_q.size(), 0);

        configure(1'b0);
        cyc(1);
        run_frame(4'h1, 1'b0, lat, rdy);
        chk("lat_1", lat, 41);
        cyc(1);
        chk_rx("rx_1", 8'h11);

        run_frame(4'h0, 1'b0, lat, rdy);
        chk("lat_0", lat, 41);
        cyc(1);
        chk_rx("rx_0", 8'h00);
        cyc(5);
        chk("rx_leftover", rx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
